// File: rtl/data_bus_sequencer_if.sv
// Request/strobe bundle between the instruction sequencer (master) and the
// data bus sequencer (slave).
interface data_bus_sequencer_if #(
  parameter int NUM_SRC = 8,
  parameter int NUM_DST = 8
);
  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic             req_valid;
  logic             req_ready;
  logic [SRC_W-1:0] req_src;
  logic [NUM_DST-1:0] req_dst;
  logic [NUM_SRC-1:0] drive_en;
  logic [NUM_DST-1:0] load_en;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output req_valid, req_src, req_dst,
    input  req_ready, drive_en, load_en, busy, done, err
  );

  modport slave (
    input  req_valid, req_src, req_dst,
    output req_ready, drive_en, load_en, busy, done, err
  );
endinterface

// File: rtl/data_bus_sequencer.sv
// Sequences one source-to-destinations move on the shared data bus through
// drive/settle, load and release phases with a single one-hot bus driver.
module data_bus_sequencer #(
  parameter int NUM_SRC       = 8,
  parameter int NUM_DST       = 8,
  parameter int SETTLE_CYCLES = 2,
  parameter int LOAD_CYCLES   = 1,
  parameter logic [NUM_SRC-1:0] DRIVE_MASK = {NUM_SRC{1'b1}}
) (
  input logic clk,
  input logic rst,
  data_bus_sequencer_if.slave bus
);

  // state   | meaning
  // IDLE    | ready for a request, bus undriven
  // DRIVE   | source drives the bus, data settling
  // LOAD    | source still driving, destination strobes high
  // RELEASE | strobes dropped, driver held one more cycle, done pulse
  typedef enum logic [1:0] {IDLE, DRIVE, LOAD, RELEASE} state_t;

  localparam int CNT_MAX = (SETTLE_CYCLES > LOAD_CYCLES) ? SETTLE_CYCLES : LOAD_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [NUM_DST-1:0] dst_q;
  logic [NUM_SRC-1:0] drive_q;
  logic [NUM_DST-1:0] load_q;
  logic               ready_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;

  logic               legal_d;
  logic [NUM_SRC-1:0] drive_d;

  always_comb begin
    legal_d = 1'b0;
    drive_d = {{(NUM_SRC-1){1'b0}}, 1'b1} << bus.req_src;
    if (int'(bus.req_src) < NUM_SRC) begin
      legal_d = DRIVE_MASK[bus.req_src] && (bus.req_dst != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dst_q   <= '0;
      drive_q <= '0;
      load_q  <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req_valid && ready_q) begin
            if (legal_d) begin
              state_q <= DRIVE;
              cnt_q   <= CNT_W'(SETTLE_CYCLES - 1);
              dst_q   <= bus.req_dst;
              drive_q <= drive_d;
              ready_q <= 1'b0;
              busy_q  <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        DRIVE: begin
          if (cnt_q == '0) begin
            state_q <= LOAD;
            cnt_q   <= CNT_W'(LOAD_CYCLES - 1);
            load_q  <= dst_q;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        LOAD: begin
          if (cnt_q == '0) begin
            state_q <= RELEASE;
            load_q  <= '0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RELEASE: begin
          // driver drops only after the strobes are already low
          state_q <= IDLE;
          drive_q <= '0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.drive_en  = drive_q;
  assign bus.load_en   = load_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_data_bus_sequencer.sv
// Directed bench: instance A uses default timing with source 6 masked off,
// instance B uses SETTLE_CYCLES=3, LOAD_CYCLES=2.
module tb_data_bus_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   inv_skip = 1'b0;

  always #5 clk = ~clk;

  data_bus_sequencer_if #(.NUM_SRC(8), .NUM_DST(8)) ifa ();
  data_bus_sequencer_if #(.NUM_SRC(8), .NUM_DST(8)) ifb ();

  data_bus_sequencer #(
    .NUM_SRC(8), .NUM_DST(8), .SETTLE_CYCLES(2), .LOAD_CYCLES(1),
    .DRIVE_MASK(8'b1011_1111)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );

  data_bus_sequencer #(
    .NUM_SRC(8), .NUM_DST(8), .SETTLE_CYCLES(3), .LOAD_CYCLES(2),
    .DRIVE_MASK(8'b1111_1111)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  logic [7:0] prev_drive_a, prev_load_a, prev_drive_b, prev_load_b;
  initial begin
    prev_drive_a = '0; prev_load_a = '0; prev_drive_b = '0; prev_load_b = '0;
  end

  // bus invariants on both instances every cycle
  always @(negedge clk) begin
    if (!rst && !inv_skip) begin
      checks++;
      if ($countones(ifa.drive_en) > 1 || $countones(ifb.drive_en) > 1) begin
        errors++;
        $display("FAIL onehot_drive a=%b b=%b required popcount<=1", ifa.drive_en, ifb.drive_en);
      end
      checks++;
      if ((ifa.load_en != 0 && ifa.drive_en == 0) || (ifb.load_en != 0 && ifb.drive_en == 0)) begin
        errors++;
        $display("FAIL load_without_drive a=%b/%b b=%b/%b", ifa.load_en, ifa.drive_en, ifb.load_en, ifb.drive_en);
      end
      checks++;
      if ((prev_drive_a != 0 && ifa.drive_en == 0 && ifa.load_en != prev_load_a) ||
          (prev_drive_b != 0 && ifb.drive_en == 0 && ifb.load_en != prev_load_b)) begin
        errors++;
        $display("FAIL load_change_on_drive_fall a=%b b=%b required unchanged", ifa.load_en, ifb.load_en);
      end
    end
    prev_drive_a = ifa.drive_en; prev_load_a = ifa.load_en;
    prev_drive_b = ifb.drive_en; prev_load_b = ifb.load_en;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    ifa.req_valid = 0; ifa.req_src = '0; ifa.req_dst = '0;
    ifb.req_valid = 0; ifb.req_src = '0; ifb.req_dst = '0;
    rst = 1;
    tick(); tick();
    checks++;
    if ({ifa.req_ready, ifa.busy, ifa.done, ifa.err} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_flags_a got=%b required=1000", {ifa.req_ready, ifa.busy, ifa.done, ifa.err});
    end
    checks++;
    if ({ifa.drive_en, ifa.load_en} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_strobes_a got=%h required=0000", {ifa.drive_en, ifa.load_en});
    end
    checks++;
    if ({ifb.req_ready, ifb.busy, ifb.done, ifb.err, ifb.drive_en, ifb.load_en} !== {4'b1000, 16'h0}) begin
      errors++;
      $display("FAIL reset_b got=%b required=%b", {ifb.req_ready, ifb.busy, ifb.done, ifb.err, ifb.drive_en, ifb.load_en}, {4'b1000, 16'h0});
    end
    rst = 0;
    tick();
    checks++;
    if (ifa.req_ready !== 1'b1 || ifa.busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle ready=%b busy=%b required 1/0", ifa.req_ready, ifa.busy);
    end
  endtask

  task automatic test_basic();
    logic [7:0] ed, el;
    ifa.req_src = 3'd2; ifa.req_dst = 8'b0000_0001; ifa.req_valid = 1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) ifa.req_valid = 0;
      ed = (c <= 4) ? 8'b0000_0100 : 8'h00;
      el = (c == 3) ? 8'b0000_0001 : 8'h00;
      checks++;
      if (ifa.drive_en !== ed) begin
        errors++; $display("FAIL basic_drive c=%0d got=%b required=%b", c, ifa.drive_en, ed);
      end
      checks++;
      if (ifa.load_en !== el) begin
        errors++; $display("FAIL basic_load c=%0d got=%b required=%b", c, ifa.load_en, el);
      end
      checks++;
      if ({ifa.done, ifa.req_ready, ifa.busy} !== {c == 4, c == 5, c <= 4}) begin
        errors++;
        $display("FAIL basic_flags c=%0d done/ready/busy got=%b required=%b", c,
                 {ifa.done, ifa.req_ready, ifa.busy}, {c == 4, c == 5, c <= 4});
      end
    end
  endtask

  task automatic test_illegal();
    logic [2:0] srcs [2];
    logic [7:0] dsts [2];
    srcs[0] = 3'd1; dsts[0] = 8'h00;
    srcs[1] = 3'd6; dsts[1] = 8'h01;
    for (int k = 0; k < 2; k++) begin
      ifa.req_src = srcs[k]; ifa.req_dst = dsts[k]; ifa.req_valid = 1;
      tick();
      ifa.req_valid = 0;
      checks++;
      if ({ifa.err, ifa.busy, ifa.req_ready, ifa.done} !== 4'b1010 || ifa.drive_en !== 0 || ifa.load_en !== 0) begin
        errors++;
        $display("FAIL illegal_err k=%0d err/busy/ready/done got=%b required=1010 drive=%b load=%b",
                 k, {ifa.err, ifa.busy, ifa.req_ready, ifa.done}, ifa.drive_en, ifa.load_en);
      end
      tick();
      checks++;
      if ({ifa.err, ifa.busy} !== 2'b00 || ifa.drive_en !== 0 || ifa.load_en !== 0) begin
        errors++;
        $display("FAIL illegal_after k=%0d err/busy got=%b required=00 drive=%b load=%b",
                 k, {ifa.err, ifa.busy}, ifa.drive_en, ifa.load_en);
      end
    end
  endtask

  task automatic test_multi_load();
    logic [7:0] ed, el;
    ifb.req_src = 3'd0; ifb.req_dst = 8'b1000_0110; ifb.req_valid = 1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 1) ifb.req_valid = 0;
      ed = (c <= 6) ? 8'b0000_0001 : 8'h00;
      el = (c == 4 || c == 5) ? 8'b1000_0110 : 8'h00;
      checks++;
      if (ifb.drive_en !== ed || ifb.load_en !== el) begin
        errors++;
        $display("FAIL multi_strobes c=%0d drive=%b load=%b required %b/%b", c, ifb.drive_en, ifb.load_en, ed, el);
      end
      checks++;
      if ({ifb.done, ifb.req_ready} !== {c == 6, c == 7}) begin
        errors++;
        $display("FAIL multi_done c=%0d done/ready got=%b required=%b", c, {ifb.done, ifb.req_ready}, {c == 6, c == 7});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ed, el;
    ifa.req_src = 3'd1; ifa.req_dst = 8'b0000_0010; ifa.req_valid = 1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) begin ifa.req_src = 3'd3; ifa.req_dst = 8'b0001_0000; end
      if (c == 6) ifa.req_valid = 0;
      ed = (c <= 4) ? 8'b0000_0010 : (c >= 6 && c <= 9) ? 8'b0000_1000 : 8'h00;
      el = (c == 3) ? 8'b0000_0010 : (c == 8) ? 8'b0001_0000 : 8'h00;
      checks++;
      if (ifa.drive_en !== ed || ifa.load_en !== el) begin
        errors++;
        $display("FAIL b2b_strobes c=%0d drive=%b load=%b required %b/%b", c, ifa.drive_en, ifa.load_en, ed, el);
      end
      checks++;
      if ({ifa.done, ifa.req_ready} !== {c == 4 || c == 9, c == 5 || c == 10}) begin
        errors++;
        $display("FAIL b2b_flags c=%0d done/ready got=%b required=%b", c,
                 {ifa.done, ifa.req_ready}, {c == 4 || c == 9, c == 5 || c == 10});
      end
    end
  endtask

  task automatic test_capture();
    ifa.req_src = 3'd4; ifa.req_dst = 8'b0010_0000; ifa.req_valid = 1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) begin ifa.req_valid = 0; ifa.req_src = 3'd5; ifa.req_dst = 8'h01; end
      if (c == 2) begin ifa.req_src = 3'd7; ifa.req_dst = 8'hFF; end
      checks++;
      if (ifa.drive_en !== ((c <= 4) ? 8'b0001_0000 : 8'h00) ||
          ifa.load_en !== ((c == 3) ? 8'b0010_0000 : 8'h00)) begin
        errors++;
        $display("FAIL capture c=%0d drive=%b load=%b required %b/%b", c, ifa.drive_en, ifa.load_en,
                 (c <= 4) ? 8'b0001_0000 : 8'h00, (c == 3) ? 8'b0010_0000 : 8'h00);
      end
    end
  endtask

  task automatic test_async_reset();
    ifb.req_src = 3'd1; ifb.req_dst = 8'b0000_0011; ifb.req_valid = 1;
    tick();
    ifb.req_valid = 0;
    tick(); tick(); tick();
    checks++;
    if (ifb.load_en !== 8'b0000_0011 || ifb.drive_en !== 8'b0000_0010) begin
      errors++;
      $display("FAIL arst_in_load drive=%b load=%b required 00000010/00000011", ifb.drive_en, ifb.load_en);
    end
    inv_skip = 1;
    #2 rst = 1;
    #1;
    checks++;
    if (ifb.drive_en !== 0 || ifb.load_en !== 0 || ifb.busy !== 0 || ifb.done !== 0 || ifb.req_ready !== 1) begin
      errors++;
      $display("FAIL arst_immediate drive=%b load=%b busy=%b done=%b ready=%b required 0/0/0/0/1",
               ifb.drive_en, ifb.load_en, ifb.busy, ifb.done, ifb.req_ready);
    end
    tick();
    rst = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (ifb.done !== 0 || ifb.busy !== 0) begin
        errors++;
        $display("FAIL arst_no_done c=%0d done=%b busy=%b required 0/0", c, ifb.done, ifb.busy);
      end
    end
    inv_skip = 0;
    ifb.req_src = 3'd5; ifb.req_dst = 8'b0100_0000; ifb.req_valid = 1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 1) ifb.req_valid = 0;
      checks++;
      if (ifb.drive_en !== ((c <= 6) ? 8'b0010_0000 : 8'h00) ||
          ifb.load_en !== ((c == 4 || c == 5) ? 8'b0100_0000 : 8'h00) ||
          ifb.done !== (c == 6)) begin
        errors++;
        $display("FAIL arst_recover c=%0d drive=%b load=%b done=%b", c, ifb.drive_en, ifb.load_en, ifb.done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    tick();
    test_illegal();
    test_multi_load();
    tick();
    test_back_to_back();
    tick();
    test_capture();
    tick();
    test_async_reset();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
